count_sample_fifo: RTL and testbench
====================================

// Module: count_sample_fifo
// PURPOSE
//   Downstream consumer of the 3-bit free-running counter: on each sample strobe,
//   captures the counter value into a small FIFO. A valid/ready consumer (display
//   or logger stage) drains the FIFO. A sticky overflow flag records any sample
//   dropped because the FIFO was full.
// PARAMETERS
//   WIDTH   3  width of count_in / out_data in bits
//   DEPTH   4  number of FIFO entries; must be a power of 2 and >= 2
//   ADDR_W  2  log2(DEPTH); pointer width
// PORTS
//   c          in   1         clock, all state updates on posedge c
//   reset      in   1         asynchronous reset, active-high
//   count_in   in   WIDTH     counter value to capture
//   sample     in   1         capture request for count_in this cycle
//   clear      in   1         synchronous flush
//   out_data   out  WIDTH     head entry of the FIFO
//   out_valid  out  1         out_data holds a valid entry
//   out_ready  in   1         consumer accepts out_data this cycle
//   level      out  ADDR_W+1  number of stored entries, 0..DEPTH
//   full       out  1         level == DEPTH
//   overflow   out  1         sticky: a sample was dropped
// BEHAVIOUR
//   Clock and reset: one clock; reset is asynchronous and active-high.
//   - While reset is high: rd_ptr=wr_ptr=0, level=0, state=EMPTY, out_valid=0,
//     out_data=0, full=0, overflow=0. Storage contents are don't-care.
//   - Release of reset takes effect at the first posedge c with reset low.
//   State machine (registered state, one of EMPTY, PARTIAL, FULL):
//     EMPTY   level==0; out_valid=0
//     PARTIAL 0<level<DEPTH; out_valid=1
//     FULL    level==DEPTH; out_valid=1, full=1
//   Per-cycle events:
//     push = sample & (state!=FULL | pop)
//     pop  = out_valid & out_ready
//     drop = sample & state==FULL & !pop
//   - push writes count_in to mem[wr_ptr]; wr_ptr increments.
//   - pop increments rd_ptr.
//   - Pointers wrap modulo DEPTH; level is tracked separately as ADDR_W+1 bits.
//   - push&pop: level is unchanged and the state is unchanged. This applies in
//     PARTIAL and FULL. In EMPTY, pop is impossible because out_valid=0.
//   - push only: level+1. Transitions EMPTY->PARTIAL, or PARTIAL->FULL when
//     level was DEPTH-1.
//   - pop only: level-1. Transitions FULL->PARTIAL, or PARTIAL->EMPTY when
//     level was 1.
//   - drop: the sample is discarded, overflow is set to 1 and remains 1 until
//     clear or reset.
//   - Latency: a sample into an EMPTY FIFO gives out_valid=1 on the next cycle,
//     with out_data equal to the captured value. There is no same-cycle bypass.
//   - out_data = mem[rd_ptr] while out_valid=1, and 0 while out_valid=0.
//   - out_data is stable while out_valid=1 and out_ready=0.
//   - out_ready while out_valid=0 has no effect.
//   - clear has priority over sample and out_ready. Next cycle: pointers=0,
//     level=0, EMPTY, overflow=0. A sample in the clear cycle is discarded and
//     does not set overflow.
//   - count_in is captured as-is. The counter's wrap from 7 to 0 has no special
//     meaning here.
//   - Reset asserted mid-operation: outputs go to reset values immediately,
//     without waiting for a clock edge. All pending entries are lost.
// TESTING
//   1. Reset, then one sample with count_in=5 and out_ready=0 -> next cycle
//      out_valid=1, out_data=5, level=1; these hold for 3 idle cycles.
//   2. Samples with count_in 1,2,3,4, then a fifth sample with count_in 6 ->
//      full=1, level=4, overflow=1. Drain with out_ready=1 -> data 1,2,3,4,
//      then out_valid=0.
//   3. FULL with head=1; sample count_in=7 together with out_ready=1 ->
//      level stays 4, overflow stays 0, the last drained value is 7.
//   4. Sample every cycle from the counter while count goes 6,7,0,1, with
//      out_ready=1 -> out_data sequence 6,7,0,1, each one cycle later;
//      level stays <=1.
//   5. level=3 and overflow=1; clear and sample in the same cycle -> next
//      cycle level=0, out_valid=0, overflow=0.
//   6. level=2; assert reset between clock edges -> out_valid, level and
//      overflow go to 0 before the next posedge c. After reset release,
//      sample count_in=3 -> out_data=3.

Source files
------------

// File: rtl/count_sample_fifo.sv
// Captures count_in into a small FIFO on each sample strobe; a valid/ready consumer drains it.
// A sticky overflow flag records samples dropped while the FIFO was full.
module count_sample_fifo #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              c,
    input  logic              reset,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              sample,
    input  logic              clear,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              overflow
);

    localparam logic [ADDR_W:0] LEVEL_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LEVEL_ONE = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]    level_q, level_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q;
    logic               full_q;
    logic               overflow_q;
    logic               push;
    logic               pop;
    logic               drop;

    assign pop  = valid_q & out_ready;
    assign push = sample & ((state_q != ST_FULL) | pop);
    assign drop = sample & (state_q == ST_FULL) & ~pop;

    // Next pointers/level; the registered head forwards count_in when the new entry becomes the head.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        data_d   = '0;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            if (push && !pop)      level_d = level_q + LEVEL_ONE;
            else if (pop && !push) level_d = level_q - LEVEL_ONE;
            if (level_d != '0) begin
                data_d = (push && (wr_ptr_q == rd_ptr_d)) ? count_in : mem_q[rd_ptr_d];
            end
        end
    end

    // Storage has no reset; contents are only read once written.
    always_ff @(posedge c) begin
        if (push && !clear) mem_q[wr_ptr_q] <= count_in;
    end

    always_ff @(posedge c or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            data_q   <= data_d;
            valid_q  <= (level_d != '0);
            full_q   <= (level_d == LEVEL_MAX);
            if (clear) begin
                state_q    <= ST_EMPTY;
                overflow_q <= 1'b0;
            end else begin
                if (drop) overflow_q <= 1'b1;
                case (state_q)
                    ST_EMPTY: begin
                        if (push) state_q <= ST_PARTIAL;
                    end
                    ST_PARTIAL: begin
                        if (push && !pop && (level_q == LEVEL_MAX - LEVEL_ONE)) state_q <= ST_FULL;
                        else if (pop && !push && (level_q == LEVEL_ONE))        state_q <= ST_EMPTY;
                    end
                    ST_FULL: begin
                        if (pop && !push) state_q <= ST_PARTIAL;
                    end
                    default: state_q <= ST_EMPTY;
                endcase
            end
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign level     = level_q;
    assign full      = full_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_count_sample_fifo.sv
// Scoreboard bench for count_sample_fifo: a reference queue predicts every output each cycle.
module tb_count_sample_fifo;

    localparam int unsigned WIDTH  = 3;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 2;

    logic              c = 1'b0;
    logic              reset = 1'b1;
    logic [WIDTH-1:0]  count_in = '0;
    logic              sample = 1'b0;
    logic              clear = 1'b0;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W:0]   level;
    logic              full;
    logic              overflow;

    int                checks = 0;
    int                failures = 0;
    logic [WIDTH-1:0]  sb [$];
    logic              exp_ovf = 1'b0;

    count_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .c         (c),
        .reset     (reset),
        .count_in  (count_in),
        .sample    (sample),
        .clear     (clear),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .full      (full),
        .overflow  (overflow)
    );

    always #5 c = ~c;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Compare every output against the scoreboard's view of the FIFO.
    task automatic check_outputs(input string tag);
        int n;
        n = sb.size();
        check({tag, ".valid"},    32'(out_valid), 32'(n != 0));
        check({tag, ".level"},    32'(level),     32'(n));
        check({tag, ".full"},     32'(full),      32'(n == int'(DEPTH)));
        check({tag, ".overflow"}, 32'(overflow),  32'(exp_ovf));
        check({tag, ".data"},     32'(out_data),  (n != 0) ? 32'(sb[0]) : 32'd0);
    endtask

    // One clock with the given inputs; called and returns at posedge+1.
    task automatic cycle(input string tag, input logic smp, input logic [WIDTH-1:0] cnt,
                         input logic rdy, input logic clr);
        logic mpop;
        logic was_full;
        sample   = smp;
        count_in = cnt;
        out_ready = rdy;
        clear    = clr;
        if (clr) begin
            sb.delete();
            exp_ovf = 1'b0;
        end else begin
            mpop     = (sb.size() != 0) && rdy;
            was_full = (sb.size() == int'(DEPTH));
            if (mpop) begin
                check({tag, ".pop_data"}, 32'(out_data), 32'(sb[0]));
                void'(sb.pop_front());
            end
            if (smp) begin
                if (!was_full || mpop) sb.push_back(cnt);
                else                   exp_ovf = 1'b1;
            end
        end
        @(posedge c);
        #1;
        sample    = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        // Reset held across two edges, released between edges.
        @(posedge c);
        #1;
        check_outputs("in_reset");
        @(negedge c);
        reset = 1'b0;
        @(posedge c);
        #1;
        check_outputs("after_reset");

        // T1: single sample, held through idle cycles.
        cycle("t1_push", 1'b1, 3'd5, 1'b0, 1'b0);
        check("t1_data", 32'(out_data), 32'd5);
        for (int i = 0; i < 3; i++) cycle("t1_idle", 1'b0, 3'd0, 1'b0, 1'b0);
        cycle("t1_drain", 1'b0, 3'd0, 1'b1, 1'b0);

        // T2: fill to full, fifth sample drops, then drain.
        for (int i = 1; i <= 4; i++) cycle("t2_fill", 1'b1, 3'(i), 1'b0, 1'b0);
        cycle("t2_drop", 1'b1, 3'd6, 1'b0, 1'b0);
        check("t2_full", 32'(full), 32'd1);
        check("t2_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 5; i++) cycle("t2_drain", 1'b0, 3'd0, 1'b1, 1'b0);
        check("t2_empty", 32'(out_valid), 32'd0);

        // T3: push and pop together while full.
        cycle("t3_clear", 1'b0, 3'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) cycle("t3_fill", 1'b1, 3'(i), 1'b0, 1'b0);
        cycle("t3_pushpop", 1'b1, 3'd7, 1'b1, 1'b0);
        check("t3_level", 32'(level), 32'd4);
        check("t3_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) cycle("t3_drain", 1'b0, 3'd0, 1'b1, 1'b0);

        // T4: stream across the counter wrap with the consumer always ready.
        for (int i = 0; i < 4; i++) cycle("t4_stream", 1'b1, 3'(6 + i), 1'b1, 1'b0);
        cycle("t4_tail", 1'b0, 3'd0, 1'b1, 1'b0);

        // T5: clear with a simultaneous sample at level 3 with overflow set.
        for (int i = 0; i < 5; i++) cycle("t5_fill", 1'b1, 3'(i + 2), 1'b0, 1'b0);
        cycle("t5_pop", 1'b0, 3'd0, 1'b1, 1'b0);
        check("t5_level3", 32'(level), 32'd3);
        cycle("t5_clear", 1'b1, 3'd5, 1'b1, 1'b1);

        // T6: asynchronous reset between edges at level 2.
        cycle("t6_fill", 1'b1, 3'd1, 1'b0, 1'b0);
        cycle("t6_fill", 1'b1, 3'd2, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        sb.delete();
        exp_ovf = 1'b0;
        check_outputs("t6_async");
        @(posedge c);
        #1;
        reset = 1'b0;
        cycle("t6_push", 1'b1, 3'd3, 1'b0, 1'b0);
        check("t6_data", 32'(out_data), 32'd3);

        // Random mix of sample/ready/clear against the scoreboard.
        for (int i = 0; i < 200; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
